// File: rtl/alu_operand_stage_pkg.sv
// Shared CPU definitions used by the EX operand stage: ALUFun encodings,
// the hardwired-zero register index, the stage register layout and the forward-hit rule.
package alu_operand_stage_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    // ALUFun[5:4] selects the functional group, [3:0] the operation within it
    localparam logic [1:0] ALU_GRP_ADD   = 2'b00;
    localparam logic [1:0] ALU_GRP_LOGIC = 2'b01;
    localparam logic [1:0] ALU_GRP_SHIFT = 2'b10;
    localparam logic [1:0] ALU_GRP_CMP   = 2'b11;

    localparam logic [5:0] ALU_ADD = 6'b000000;
    localparam logic [5:0] ALU_SUB = 6'b000001;
    localparam logic [5:0] ALU_AND = 6'b011000;
    localparam logic [5:0] ALU_OR  = 6'b011110;
    localparam logic [5:0] ALU_XOR = 6'b010110;
    localparam logic [5:0] ALU_NOR = 6'b010001;
    localparam logic [5:0] ALU_A   = 6'b011010;
    localparam logic [5:0] ALU_SLL = 6'b100000;
    localparam logic [5:0] ALU_SRL = 6'b100001;
    localparam logic [5:0] ALU_SRA = 6'b100011;
    localparam logic [5:0] ALU_EQ  = 6'b110011;
    localparam logic [5:0] ALU_NEQ = 6'b110001;
    localparam logic [5:0] ALU_LT  = 6'b110101;

    typedef struct packed {
        logic             valid;
        logic [5:0]       alufun;
        logic             sign;
        logic [XLEN-1:0]  rs_data;
        logic [XLEN-1:0]  rt_data;
        logic [XLEN-1:0]  imm;
        logic [4:0]       shamt;
        logic             alusrc1;
        logic             alusrc2;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
        logic             memwrite;
    } stage_t;

    function automatic logic fwd_hit(input logic we, input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] src);
        return we && (rd != REG_ZERO) && (rd == src);
    endfunction

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// Forwarding comparator/mux for one source operand: EX/MEM beats MEM/WB beats held data,
// and register zero is never forwarded.
module fwd_mux
    import alu_operand_stage_pkg::*;
(
    input  logic [REG_W-1:0] i_src,
    input  logic [XLEN-1:0]  i_held,
    input  logic             i_exmem_we,
    input  logic [REG_W-1:0] i_exmem_rd,
    input  logic [XLEN-1:0]  i_exmem_result,
    input  logic             i_memwb_we,
    input  logic [REG_W-1:0] i_memwb_rd,
    input  logic [XLEN-1:0]  i_memwb_result,
    output logic [XLEN-1:0]  o_data
);

    always_comb begin
        o_data = i_held;
        if (fwd_hit(i_exmem_we, i_exmem_rd, i_src))
            o_data = i_exmem_result;
        else if (fwd_hit(i_memwb_we, i_memwb_rd, i_src))
            o_data = i_memwb_result;
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX stage register with operand forwarding, stall/flush control and
// load-use hazard detection.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [5:0]       id_ALUFun,
    input  logic             id_Sign,
    input  logic [XLEN-1:0]  id_rs_data,
    input  logic [XLEN-1:0]  id_rt_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_shamt,
    input  logic             id_ALUSrc1,
    input  logic             id_ALUSrc2,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_RegWrite,
    input  logic             id_MemRead,
    input  logic             id_MemWrite,
    input  logic             exmem_RegWrite,
    input  logic [REG_W-1:0] exmem_rd,
    input  logic [XLEN-1:0]  exmem_result,
    input  logic             memwb_RegWrite,
    input  logic [REG_W-1:0] memwb_rd,
    input  logic [XLEN-1:0]  memwb_result,
    input  logic             stall,
    input  logic             flush,
    output logic             ex_valid,
    output logic [5:0]       ex_ALUFun,
    output logic             ex_Sign,
    output logic [XLEN-1:0]  ex_A,
    output logic [XLEN-1:0]  ex_B,
    output logic [XLEN-1:0]  ex_store_data,
    output logic [REG_W-1:0] ex_rd,
    output logic             ex_RegWrite,
    output logic             ex_MemRead,
    output logic             ex_MemWrite,
    output logic             load_use_stall
);

    stage_t          r_stage;
    stage_t          w_load;
    logic [XLEN-1:0] w_fwd_rs;
    logic [XLEN-1:0] w_fwd_rt;

    always_comb begin
        w_load          = '0;
        w_load.valid    = id_valid;
        w_load.alufun   = id_ALUFun;
        w_load.sign     = id_Sign;
        w_load.rs_data  = id_rs_data;
        w_load.rt_data  = id_rt_data;
        w_load.imm      = id_imm;
        w_load.shamt    = id_shamt;
        w_load.alusrc1  = id_ALUSrc1;
        w_load.alusrc2  = id_ALUSrc2;
        w_load.rs       = id_rs;
        w_load.rt       = id_rt;
        w_load.rd       = id_rd;
        w_load.regwrite = id_RegWrite;
        w_load.memread  = id_MemRead;
        w_load.memwrite = id_MemWrite;
    end

    // While held, a retiring MEM/WB write is captured so the operand is still
    // correct once that producer has left the pipeline.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_stage <= '0;
        end else if (stall) begin
            if (fwd_hit(memwb_RegWrite, memwb_rd, r_stage.rs))
                r_stage.rs_data <= memwb_result;
            if (fwd_hit(memwb_RegWrite, memwb_rd, r_stage.rt))
                r_stage.rt_data <= memwb_result;
        end else begin
            r_stage <= w_load;
        end
    end

    fwd_mux u_fwd_rs (
        .i_src          (r_stage.rs),
        .i_held         (r_stage.rs_data),
        .i_exmem_we     (exmem_RegWrite),
        .i_exmem_rd     (exmem_rd),
        .i_exmem_result (exmem_result),
        .i_memwb_we     (memwb_RegWrite),
        .i_memwb_rd     (memwb_rd),
        .i_memwb_result (memwb_result),
        .o_data         (w_fwd_rs)
    );

    fwd_mux u_fwd_rt (
        .i_src          (r_stage.rt),
        .i_held         (r_stage.rt_data),
        .i_exmem_we     (exmem_RegWrite),
        .i_exmem_rd     (exmem_rd),
        .i_exmem_result (exmem_result),
        .i_memwb_we     (memwb_RegWrite),
        .i_memwb_rd     (memwb_rd),
        .i_memwb_result (memwb_result),
        .o_data         (w_fwd_rt)
    );

    assign ex_valid      = r_stage.valid;
    assign ex_ALUFun     = r_stage.alufun;
    assign ex_Sign       = r_stage.sign;
    assign ex_rd         = r_stage.rd;
    assign ex_RegWrite   = r_stage.regwrite;
    assign ex_MemRead    = r_stage.memread;
    assign ex_MemWrite   = r_stage.memwrite;
    assign ex_A          = r_stage.alusrc1 ? {27'b0, r_stage.shamt} : w_fwd_rs;
    assign ex_B          = r_stage.alusrc2 ? r_stage.imm : w_fwd_rt;
    assign ex_store_data = w_fwd_rt;

    assign load_use_stall = r_stage.valid && r_stage.memread && (r_stage.rd != REG_ZERO)
                         && id_valid && ((r_stage.rd == id_rs) || (r_stage.rd == id_rt));

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_Sign, id_ALUSrc1, id_ALUSrc2;
    logic [5:0]  id_ALUFun;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt, id_rs, id_rt, id_rd;
    logic        id_RegWrite, id_MemRead, id_MemWrite;
    logic        exmem_RegWrite, memwb_RegWrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        stall, flush;
    logic        ex_valid, ex_Sign, ex_RegWrite, ex_MemRead, ex_MemWrite, load_use_stall;
    logic [5:0]  ex_ALUFun;
    logic [31:0] ex_A, ex_B, ex_store_data;
    logic [4:0]  ex_rd;

    alu_operand_stage dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_ALUFun(id_ALUFun), .id_Sign(id_Sign),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_shamt(id_shamt), .id_ALUSrc1(id_ALUSrc1), .id_ALUSrc2(id_ALUSrc2),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
        .exmem_RegWrite(exmem_RegWrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_RegWrite(memwb_RegWrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_ALUFun(ex_ALUFun), .ex_Sign(ex_Sign),
        .ex_A(ex_A), .ex_B(ex_B), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .load_use_stall(load_use_stall)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model: what the ID/EX latch holds, as plain variables.
    logic        m_valid, m_sign, m_src1, m_src2, m_rw, m_mr, m_mw;
    logic [5:0]  m_fun;
    logic [31:0] m_rs_data, m_rt_data, m_imm;
    logic [4:0]  m_shamt, m_rs, m_rt, m_rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] held);
        if (exmem_RegWrite && exmem_rd != 0 && exmem_rd == idx) return exmem_result;
        if (memwb_RegWrite && memwb_rd != 0 && memwb_rd == idx) return memwb_result;
        return held;
    endfunction

    task automatic model_clear();
        {m_valid, m_sign, m_src1, m_src2, m_rw, m_mr, m_mw} = '0;
        m_fun = '0; m_rs_data = '0; m_rt_data = '0; m_imm = '0;
        m_shamt = '0; m_rs = '0; m_rt = '0; m_rd = '0;
    endtask

    task automatic model_update();
        if (reset || flush) begin
            model_clear();
        end else if (stall) begin
            if (memwb_RegWrite && memwb_rd != 0 && memwb_rd == m_rs) m_rs_data = memwb_result;
            if (memwb_RegWrite && memwb_rd != 0 && memwb_rd == m_rt) m_rt_data = memwb_result;
        end else begin
            m_valid = id_valid; m_fun = id_ALUFun; m_sign = id_Sign;
            m_rs_data = id_rs_data; m_rt_data = id_rt_data; m_imm = id_imm;
            m_shamt = id_shamt; m_src1 = id_ALUSrc1; m_src2 = id_ALUSrc2;
            m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
            m_rw = id_RegWrite; m_mr = id_MemRead; m_mw = id_MemWrite;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #2;
    endtask

    task automatic clear_fwd();
        exmem_RegWrite = 0; exmem_rd = 0; exmem_result = 0;
        memwb_RegWrite = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic clear_id();
        id_valid = 0; id_ALUFun = 0; id_Sign = 0; id_rs_data = 0; id_rt_data = 0;
        id_imm = 0; id_shamt = 0; id_ALUSrc1 = 0; id_ALUSrc2 = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_RegWrite = 0; id_MemRead = 0; id_MemWrite = 0;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ex_valid", 32'(ex_valid), 32'(m_valid));
            chk("ex_ALUFun", 32'(ex_ALUFun), 32'(m_fun));
            chk("ex_Sign", 32'(ex_Sign), 32'(m_sign));
            chk("ex_rd", 32'(ex_rd), 32'(m_rd));
            chk("ex_RegWrite", 32'(ex_RegWrite), 32'(m_rw));
            chk("ex_MemRead", 32'(ex_MemRead), 32'(m_mr));
            chk("ex_MemWrite", 32'(ex_MemWrite), 32'(m_mw));
            chk("ex_A", ex_A, m_src1 ? {27'b0, m_shamt} : fwd(m_rs, m_rs_data));
            chk("ex_B", ex_B, m_src2 ? m_imm : fwd(m_rt, m_rt_data));
            chk("ex_store_data", ex_store_data, fwd(m_rt, m_rt_data));
            chk("load_use_stall", 32'(load_use_stall),
                32'(m_valid && m_mr && m_rd != 0 && id_valid && (m_rd == id_rs || m_rd == id_rt)));
        end
    end

    initial begin
        model_clear();
        reset = 1; stall = 0; flush = 0;
        clear_id(); clear_fwd();
        id_valid = 1; id_RegWrite = 1; id_rs_data = 32'h99;
        step();
        chk_en = 1'b1;
        // Reset state, with register-0 forwarding attempted
        exmem_RegWrite = 1; exmem_rd = 0; exmem_result = 32'hFFFF;
        memwb_RegWrite = 1; memwb_rd = 0; memwb_result = 32'h1111;
        #1;
        chk("rst_valid", 32'(ex_valid), 0);
        chk("rst_A", ex_A, 0);
        chk("rst_B", ex_B, 0);
        chk("rst_store", ex_store_data, 0);
        reset = 0; clear_fwd(); clear_id();

        // Plain register-to-register transfer
        id_valid = 1; id_rs = 1; id_rt = 2; id_rs_data = 5; id_rt_data = 7;
        step();
        #1;
        chk("basic_A", ex_A, 5);
        chk("basic_B", ex_B, 7);
        chk("basic_valid", 32'(ex_valid), 1);

        // EX/MEM has priority over MEM/WB
        id_rs = 3; id_rs_data = 32'h11;
        step();
        exmem_RegWrite = 1; exmem_rd = 3; exmem_result = 32'hAAAA;
        memwb_RegWrite = 1; memwb_rd = 3; memwb_result = 32'h5555;
        #1;
        chk("prio_A", ex_A, 32'hAAAA);
        exmem_RegWrite = 0;
        #1;
        chk("memwb_A", ex_A, 32'h5555);
        clear_fwd();

        // Register zero is never forwarded
        id_rs = 0; id_rs_data = 32'h77;
        step();
        exmem_RegWrite = 1; exmem_rd = 0; exmem_result = 32'hFFFF;
        #1;
        chk("r0_A", ex_A, 32'h77);
        clear_fwd();

        // Shamt / immediate selection
        id_ALUSrc1 = 1; id_shamt = 5'd17; id_ALUSrc2 = 1; id_imm = 32'hCAFE0000;
        step();
        #1;
        chk("shamt_A", ex_A, 32'd17);
        chk("imm_B", ex_B, 32'hCAFE0000);
        chk("store_rt", ex_store_data, 7);
        id_ALUSrc1 = 0; id_ALUSrc2 = 0;

        // Load-use hazard
        id_MemRead = 1; id_rd = 8; id_valid = 1;
        step();
        id_MemRead = 0; id_rd = 0; id_rs = 1; id_rt = 8;
        #1;
        chk("lu_hit", 32'(load_use_stall), 1);
        id_MemRead = 1; id_rd = 0;
        step();
        id_MemRead = 0; id_rt = 0;
        #1;
        chk("lu_r0", 32'(load_use_stall), 0);

        // MEM/WB retirement captured during a three-cycle stall
        id_rt = 9; id_rt_data = 32'h42; id_rs = 1;
        step();
        stall = 1; id_rt_data = 32'hDEAD; id_rt = 4;
        memwb_RegWrite = 1; memwb_rd = 9; memwb_result = 32'h1234;
        repeat (3) step();
        clear_fwd(); stall = 0;
        #1;
        chk("stall_B", ex_B, 32'h1234);
        chk("stall_store", ex_store_data, 32'h1234);

        // Flush overrides stall; reset overrides stall
        id_valid = 1; id_RegWrite = 1; stall = 1; flush = 1;
        step();
        #1;
        chk("flush_valid", 32'(ex_valid), 0);
        chk("flush_rw", 32'(ex_RegWrite), 0);
        stall = 0; flush = 0; id_MemRead = 1; id_rd = 6; id_rs_data = 32'h55;
        step();
        stall = 1;
        step();
        reset = 1;
        step();
        reset = 0; stall = 0; clear_id();
        #1;
        chk("rst_mid_valid", 32'(ex_valid), 0);
        chk("rst_mid_A", ex_A, 0);
        chk("rst_mid_rd", 32'(ex_rd), 0);
        chk("rst_mid_mr", 32'(ex_MemRead), 0);

        // Randomized traffic with small register indices so forwarding hits often
        for (int i = 0; i < 3000; i++) begin
            id_valid = 1'($urandom); id_ALUFun = 6'($urandom); id_Sign = 1'($urandom);
            id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
            id_shamt = 5'($urandom); id_ALUSrc1 = ($urandom_range(0, 3) == 0);
            id_ALUSrc2 = ($urandom_range(0, 3) == 0);
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            id_rd = 5'($urandom_range(0, 3));
            id_RegWrite = 1'($urandom); id_MemRead = 1'($urandom); id_MemWrite = 1'($urandom);
            exmem_RegWrite = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3));
            exmem_result = $urandom;
            memwb_RegWrite = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3));
            memwb_result = $urandom;
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 49) == 0);
            step();
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
